// File: rtl/avmm_timer_pkg.sv
// Shared register map and bit positions for the multi-channel interval timer.
// Pure definitions: no logic, no latency, no flow control.
package avmm_timer_pkg;

  localparam logic [2:0] REG_STATUS   = 3'd0;
  localparam logic [2:0] REG_CONTROL  = 3'd1;
  localparam logic [2:0] REG_PERIOD_L = 3'd2;
  localparam logic [2:0] REG_PERIOD_H = 3'd3;
  localparam logic [2:0] REG_SNAP_L   = 3'd4;
  localparam logic [2:0] REG_SNAP_H   = 3'd5;
  localparam logic [2:0] REG_PRESCALE = 3'd6;
  localparam logic [2:0] REG_PENDING  = 3'd7;

  localparam int CTL_ITO   = 0;
  localparam int CTL_CONT  = 1;
  localparam int CTL_START = 2;
  localparam int CTL_STOP  = 3;

  localparam int STS_TIMEOUT = 0;
  localparam int STS_RUNNING = 1;

endpackage

// File: rtl/avmm_timer_channel.sv
// One timer channel: prescaler, down-counter, period, snapshot and timeout state.
// Register writes take effect on the strobe edge; no backpressure (always accepts).
module avmm_timer_channel
  import avmm_timer_pkg::*;
#(
  parameter int              CNT_W        = 32,
  parameter int              DATA_W       = 32,
  parameter int              PRE_W        = 8,
  parameter longint unsigned RESET_PERIOD = 499999
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              wr_status,
  input  logic              wr_control,
  input  logic              wr_period_l,
  input  logic              wr_period_h,
  input  logic              wr_snap,
  input  logic              wr_prescale,
  input  logic [DATA_W-1:0] writedata,
  output logic [DATA_W-1:0] status_dat,
  output logic [DATA_W-1:0] control_dat,
  output logic [DATA_W-1:0] period_l_dat,
  output logic [DATA_W-1:0] period_h_dat,
  output logic [DATA_W-1:0] snap_l_dat,
  output logic [DATA_W-1:0] snap_h_dat,
  output logic [DATA_W-1:0] prescale_dat,
  output logic              irq
);

  // Period/snapshot are viewed through a zero-extended window of two data words,
  // so the high half naturally reads 0 and drops writes when CNT_W <= DATA_W.
  localparam int               EXT_W   = (CNT_W > 2*DATA_W) ? CNT_W : 2*DATA_W;
  localparam logic [CNT_W-1:0] RST_VAL = CNT_W'(RESET_PERIOD);
  localparam bit               HAS_H   = (CNT_W > DATA_W);

  logic             running;
  logic             timeout;
  logic             force_reload;
  logic [1:0]       control;
  logic [PRE_W-1:0] prescale;
  logic [PRE_W-1:0] pre_cnt;
  logic [CNT_W-1:0] period;
  logic [CNT_W-1:0] counter;
  logic [CNT_W-1:0] snapshot;
  logic [EXT_W-1:0] period_ext;
  logic [EXT_W-1:0] snap_ext;
  logic [EXT_W-1:0] period_wr;
  logic             start;
  logic             stop;
  logic             tick;
  logic             expire;

  assign period_ext = EXT_W'(period);
  assign snap_ext   = EXT_W'(snapshot);
  assign start      = wr_control & writedata[CTL_START];
  assign stop       = wr_control & writedata[CTL_STOP];
  assign tick       = running & (pre_cnt == '0);
  assign expire     = tick & (counter == '0);

  always_comb begin
    period_wr = period_ext;
    if (wr_period_l) period_wr[DATA_W-1:0]        = writedata;
    if (wr_period_h) period_wr[2*DATA_W-1:DATA_W] = writedata;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      running      <= 1'b0;
      timeout      <= 1'b0;
      force_reload <= 1'b0;
      control      <= '0;
      prescale     <= '0;
      pre_cnt      <= '0;
      period       <= RST_VAL;
      counter      <= RST_VAL;
      snapshot     <= '0;
    end else begin
      force_reload <= wr_period_l | (wr_period_h & HAS_H);
      if (wr_period_l | wr_period_h) period <= period_wr[CNT_W-1:0];
      if (wr_control) control <= {writedata[CTL_CONT], writedata[CTL_ITO]};
      if (wr_prescale) prescale <= PRE_W'(writedata);
      if (wr_snap) snapshot <= counter;

      // START beats STOP, the post-period-write reload and a one-shot expiry.
      if (start) running <= 1'b1;
      else if (force_reload | stop | (expire & ~control[CTL_CONT])) running <= 1'b0;

      if (force_reload) counter <= period;
      else if (tick) counter <= expire ? period : counter - 1'b1;

      if (start | force_reload) pre_cnt <= prescale;
      else if (running) pre_cnt <= tick ? prescale : pre_cnt - 1'b1;

      // A new expiry outranks a coincident clear so no event is lost.
      if (expire) timeout <= 1'b1;
      else if (wr_status) timeout <= 1'b0;
    end
  end

  assign status_dat   = DATA_W'({running, timeout});
  assign control_dat  = DATA_W'(control);
  assign period_l_dat = period_ext[DATA_W-1:0];
  assign period_h_dat = period_ext[2*DATA_W-1:DATA_W];
  assign snap_l_dat   = snap_ext[DATA_W-1:0];
  assign snap_h_dat   = snap_ext[2*DATA_W-1:DATA_W];
  assign prescale_dat = DATA_W'(prescale);
  assign irq          = timeout & control[CTL_ITO];

endmodule

// File: rtl/avmm_multi_interval_timer.sv
// NUM_CH interval timers behind one Avalon-MM slave with address decode and read mux.
// Read latency 1 (readdata flopped every clock); writes always accepted, no wait states.
module avmm_multi_interval_timer
  import avmm_timer_pkg::*;
#(
  parameter int              NUM_CH       = 4,
  parameter int              CNT_W        = 32,
  parameter int              DATA_W       = 32,
  parameter int              PRE_W        = 8,
  parameter longint unsigned RESET_PERIOD = 499999
) (
  input  logic                        clk,
  input  logic                        reset_n,
  input  logic [$clog2(NUM_CH)+2:0]   address,
  input  logic                        chipselect,
  input  logic                        write_n,
  input  logic [DATA_W-1:0]           writedata,
  output logic [DATA_W-1:0]           readdata,
  output logic [NUM_CH-1:0]           irq_vec,
  output logic                        irq
);

  localparam int AW = $clog2(NUM_CH) + 3;

  logic [2:0]        reg_sel;
  logic [AW-1:0]     ch_sel;
  logic              wr_en;
  logic [DATA_W-1:0] rd_mux;

  logic [DATA_W-1:0] status_dat   [NUM_CH];
  logic [DATA_W-1:0] control_dat  [NUM_CH];
  logic [DATA_W-1:0] period_l_dat [NUM_CH];
  logic [DATA_W-1:0] period_h_dat [NUM_CH];
  logic [DATA_W-1:0] snap_l_dat   [NUM_CH];
  logic [DATA_W-1:0] snap_h_dat   [NUM_CH];
  logic [DATA_W-1:0] prescale_dat [NUM_CH];

  assign reg_sel = address[2:0];
  assign ch_sel  = address >> 3;
  assign wr_en   = chipselect & ~write_n;

  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    logic hit;
    assign hit = wr_en & (ch_sel == AW'(i));

    avmm_timer_channel #(
      .CNT_W       (CNT_W),
      .DATA_W      (DATA_W),
      .PRE_W       (PRE_W),
      .RESET_PERIOD(RESET_PERIOD)
    ) u_ch (
      .clk         (clk),
      .reset_n     (reset_n),
      .wr_status   (hit & (reg_sel == REG_STATUS)),
      .wr_control  (hit & (reg_sel == REG_CONTROL)),
      .wr_period_l (hit & (reg_sel == REG_PERIOD_L)),
      .wr_period_h (hit & (reg_sel == REG_PERIOD_H)),
      .wr_snap     (hit & ((reg_sel == REG_SNAP_L) | (reg_sel == REG_SNAP_H))),
      .wr_prescale (hit & (reg_sel == REG_PRESCALE)),
      .writedata   (writedata),
      .status_dat  (status_dat[i]),
      .control_dat (control_dat[i]),
      .period_l_dat(period_l_dat[i]),
      .period_h_dat(period_h_dat[i]),
      .snap_l_dat  (snap_l_dat[i]),
      .snap_h_dat  (snap_h_dat[i]),
      .prescale_dat(prescale_dat[i]),
      .irq         (irq_vec[i])
    );
  end

  // Channel indices beyond NUM_CH match no entry and read as zero.
  always_comb begin
    rd_mux = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      if (ch_sel == AW'(i)) begin
        case (reg_sel)
          REG_STATUS:   rd_mux = status_dat[i];
          REG_CONTROL:  rd_mux = control_dat[i];
          REG_PERIOD_L: rd_mux = period_l_dat[i];
          REG_PERIOD_H: rd_mux = period_h_dat[i];
          REG_SNAP_L:   rd_mux = snap_l_dat[i];
          REG_SNAP_H:   rd_mux = snap_h_dat[i];
          REG_PRESCALE: rd_mux = prescale_dat[i];
          REG_PENDING:  rd_mux = DATA_W'(irq_vec);
        endcase
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) readdata <= '0;
    else          readdata <= rd_mux;
  end

  assign irq = |irq_vec;

endmodule

// File: tb/tb_avmm_multi_interval_timer.sv
// Directed bench: register table after reset, then timed sequences per channel,
// plus a narrow-bus/wide-counter build with an out-of-range channel.
module tb_avmm_multi_interval_timer;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset_n;
  logic [4:0]  address;
  logic        chipselect;
  logic        write_n;
  logic [31:0] writedata;
  logic [31:0] readdata;
  logic [3:0]  irq_vec;
  logic        irq;

  logic [4:0]  address2;
  logic        chipselect2;
  logic        write_n2;
  logic [15:0] writedata2;
  logic [15:0] readdata2;
  logic [2:0]  irq_vec2;
  logic        irq2;

  avmm_multi_interval_timer u_dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .address   (address),
    .chipselect(chipselect),
    .write_n   (write_n),
    .writedata (writedata),
    .readdata  (readdata),
    .irq_vec   (irq_vec),
    .irq       (irq)
  );

  avmm_multi_interval_timer #(.NUM_CH(3), .CNT_W(48), .DATA_W(16)) u_dut2 (
    .clk       (clk),
    .reset_n   (reset_n),
    .address   (address2),
    .chipselect(chipselect2),
    .write_n   (write_n2),
    .writedata (writedata2),
    .readdata  (readdata2),
    .irq_vec   (irq_vec2),
    .irq       (irq2)
  );

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct {
    logic [4:0]  addr;
    bit          is_wr;
    logic [31:0] data;
    string       name;
  } vec_t;

  vec_t tbl [24];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic wr(input logic [4:0] a, input logic [31:0] d);
    address = a; writedata = d; chipselect = 1'b1; write_n = 1'b0;
    @(posedge clk); #1;
    chipselect = 1'b0; write_n = 1'b1;
  endtask

  task automatic rd(input logic [4:0] a, output logic [31:0] d);
    address = a; chipselect = 1'b1; write_n = 1'b1;
    @(posedge clk); #1;
    d = readdata; chipselect = 1'b0;
  endtask

  task automatic wr2(input logic [4:0] a, input logic [15:0] d);
    address2 = a; writedata2 = d; chipselect2 = 1'b1; write_n2 = 1'b0;
    @(posedge clk); #1;
    chipselect2 = 1'b0; write_n2 = 1'b1;
  endtask

  task automatic rd2(input logic [4:0] a, output logic [15:0] d);
    address2 = a; chipselect2 = 1'b1; write_n2 = 1'b1;
    @(posedge clk); #1;
    d = readdata2; chipselect2 = 1'b0;
  endtask

  task automatic wait_until(input int c);
    while (cyc < c) begin
      @(posedge clk); #1;
    end
  endtask

  initial begin
    logic [31:0] rdv;
    logic [15:0] rdv2;
    int cs;

    tbl[0]  = '{5'd2,  1'b0, 32'h0007A11F, "c0_period_l_rst"};
    tbl[1]  = '{5'd3,  1'b0, 32'h0,        "c0_period_h_rst"};
    tbl[2]  = '{5'd0,  1'b0, 32'h0,        "c0_status_rst"};
    tbl[3]  = '{5'd1,  1'b0, 32'h0,        "c0_control_rst"};
    tbl[4]  = '{5'd4,  1'b0, 32'h0,        "c0_snap_l_rst"};
    tbl[5]  = '{5'd6,  1'b0, 32'h0,        "c0_prescale_rst"};
    tbl[6]  = '{5'd7,  1'b0, 32'h0,        "c0_pending_rst"};
    tbl[7]  = '{5'd30, 1'b1, 32'h1FF,      ""};
    tbl[8]  = '{5'd30, 1'b0, 32'hFF,       "c3_prescale_trunc"};
    tbl[9]  = '{5'd27, 1'b1, 32'h1234,     ""};
    tbl[10] = '{5'd27, 1'b0, 32'h0,        "c3_period_h_ignored"};
    tbl[11] = '{5'd26, 1'b1, 32'h55,       ""};
    tbl[12] = '{5'd26, 1'b0, 32'h55,       "c3_period_l_rdback"};
    tbl[13] = '{5'd25, 1'b1, 32'hC,        ""};
    tbl[14] = '{5'd24, 1'b0, 32'h2,        "c3_start_stop_running"};
    tbl[15] = '{5'd25, 1'b0, 32'h0,        "c3_control_strobes_rd0"};
    tbl[16] = '{5'd25, 1'b1, 32'h8,        ""};
    tbl[17] = '{5'd24, 1'b0, 32'h0,        "c3_stop"};
    tbl[18] = '{5'd25, 1'b1, 32'h3,        ""};
    tbl[19] = '{5'd25, 1'b0, 32'h3,        "c3_control_rdback"};
    tbl[20] = '{5'd25, 1'b1, 32'h0,        ""};
    tbl[21] = '{5'd25, 1'b0, 32'h0,        "c3_control_clear"};
    tbl[22] = '{5'd30, 1'b1, 32'h0,        ""};
    tbl[23] = '{5'd30, 1'b0, 32'h0,        "c3_prescale_zero"};

    reset_n = 1'b0; address = '0; chipselect = 1'b0; write_n = 1'b1; writedata = '0;
    address2 = '0; chipselect2 = 1'b0; write_n2 = 1'b1; writedata2 = '0;
    repeat (3) @(posedge clk);
    #1 reset_n = 1'b1;
    @(posedge clk); #1;
    check("rst_irq", irq, 1'b0);
    check("rst_irq_vec", irq_vec, 4'h0);
    check("rst_readdata", readdata, 32'h0);

    for (int i = 0; i < 24; i++) begin
      if (tbl[i].is_wr) wr(tbl[i].addr, tbl[i].data);
      else begin
        rd(tbl[i].addr, rdv);
        check(tbl[i].name, rdv, tbl[i].data);
      end
    end

    // ch1 continuous: period 9, prescale 1 -> timeout every 20 clks
    wr(5'd10, 32'd9);
    wr(5'd14, 32'd1);
    wr(5'd9, 32'h7);
    cs = cyc;
    wait_until(cs + 19);
    check("c1_irq_before_20", irq_vec[1], 1'b0);
    wait_until(cs + 20);
    check("c1_irq_at_20", irq_vec[1], 1'b1);
    check("c1_irq_or", irq, 1'b1);
    rd(5'd15, rdv);
    check("c1_pending", rdv, 32'h2);
    rd(5'd7, rdv);
    check("c0_pending_mirror", rdv, 32'h2);
    wr(5'd8, 32'h0);
    check("c1_irq_cleared", irq_vec[1], 1'b0);
    wait_until(cs + 39);
    check("c1_irq_before_40", irq_vec[1], 1'b0);
    wait_until(cs + 40);
    check("c1_irq_at_40", irq_vec[1], 1'b1);
    wr(5'd9, 32'h8);
    wr(5'd8, 32'h0);
    check("c1_stopped_irq", irq, 1'b0);

    // ch2 one-shot: period 3, start lands on the force_reload cycle
    wr(5'd18, 32'd3);
    wr(5'd17, 32'h5);
    cs = cyc;
    wait_until(cs + 3);
    check("c2_os_before", irq_vec[2], 1'b0);
    wait_until(cs + 4);
    check("c2_os_timeout", irq_vec[2], 1'b1);
    rd(5'd16, rdv);
    check("c2_os_status", rdv, 32'h1);
    wr(5'd20, 32'h0);
    rd(5'd20, rdv);
    check("c2_os_counter_holds", rdv, 32'd3);
    wr(5'd16, 32'h0);
    wr(5'd17, 32'h5);
    cs = cyc;
    wait_until(cs + 3);
    check("c2_os2_before", irq_vec[2], 1'b0);
    wait_until(cs + 4);
    check("c2_os2_timeout", irq_vec[2], 1'b1);
    wr(5'd16, 32'h0);
    wr(5'd17, 32'h0);

    // ch0 running, period rewrite forces reload and stop
    wr(5'd1, 32'h4);
    repeat (3) begin @(posedge clk); #1; end
    wr(5'd2, 32'd100);
    rd(5'd0, rdv);
    check("c0_running_pre_reload", rdv, 32'h2);
    wr(5'd4, 32'h0);
    rd(5'd4, rdv);
    check("c0_reload_counter", rdv, 32'd100);
    rd(5'd0, rdv);
    check("c0_reload_stopped", rdv, 32'h0);
    wr(5'd1, 32'h4);
    cs = cyc;
    wait_until(cs + 10);
    wr(5'd4, 32'h0);
    rd(5'd4, rdv);
    check("c0_snap_after_10", rdv, 32'd90);
    wr(5'd1, 32'h8);

    // ch3 status clear coincident with expiry
    wr(5'd26, 32'd4);
    wr(5'd25, 32'h5);
    cs = cyc;
    wait_until(cs + 4);
    wr(5'd24, 32'h0);
    check("c3_clear_vs_timeout_irq", irq_vec[3], 1'b1);
    rd(5'd24, rdv);
    check("c3_clear_vs_timeout_sts", rdv, 32'h1);
    wr(5'd24, 32'h0);
    rd(5'd24, rdv);
    check("c3_cleared", rdv, 32'h0);

    // ch2 period 0 continuous: timeout every tick
    wr(5'd18, 32'd0);
    wr(5'd17, 32'h7);
    cs = cyc;
    wait_until(cs + 1);
    check("c2_p0_timeout", irq_vec[2], 1'b1);
    wr(5'd16, 32'h0);
    check("c2_p0_clear_lost", irq_vec[2], 1'b1);
    rd(5'd16, rdv);
    check("c2_p0_status", rdv, 32'h3);

    // asynchronous reset mid-count
    reset_n = 1'b0;
    #2;
    check("async_rst_irq", irq, 1'b0);
    check("async_rst_readdata", readdata, 32'h0);
    #2 reset_n = 1'b1;
    @(posedge clk); #1;
    rd(5'd16, rdv);
    check("c2_status_after_rst", rdv, 32'h0);
    rd(5'd18, rdv);
    check("c2_period_after_rst", rdv, 32'h0007A11F);

    // 48-bit counter on a 16-bit bus, 3 channels
    rd2(5'd2, rdv2);
    check("w_period_l_rst", rdv2, 16'hA11F);
    rd2(5'd3, rdv2);
    check("w_period_h_rst", rdv2, 16'h0007);
    wr2(5'd3, 16'hBEEF);
    rd2(5'd3, rdv2);
    check("w_period_h_rdback", rdv2, 16'hBEEF);
    rd2(5'd2, rdv2);
    check("w_period_l_kept", rdv2, 16'hA11F);
    wr2(5'd26, 16'h1234);
    rd2(5'd26, rdv2);
    check("w_oor_read", rdv2, 16'h0);
    rd2(5'd18, rdv2);
    check("w_c2_untouched", rdv2, 16'hA11F);
    check("w_irq", irq2, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
